// File: rtl/vi_pattern_gen.sv
// Video timing and test-pattern source producing vo_vs/vo_hs/vo_de/vo_data (RGB565).
// Optional horizontal scrolling of patterns 01/10/11 under `VI_PATTERN_GEN_SCROLL_EN.
module vi_pattern_gen #(
   parameter int unsigned H_DISP     = 1280,
   parameter int unsigned H_FP       = 110,
   parameter int unsigned H_SYNC     = 40,
   parameter int unsigned H_BP       = 220,
   parameter int unsigned V_DISP     = 720,
   parameter int unsigned V_FP       = 5,
   parameter int unsigned V_SYNC     = 5,
   parameter int unsigned V_BP       = 20,
   parameter int unsigned CHECK_LOG2 = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [15:0] solid_color,
   output logic        vo_vs,
   output logic        vo_hs,
   output logic        vo_de,
   output logic [15:0] vo_data,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
   localparam int unsigned W_H     = $clog2(H_TOTAL);
   localparam int unsigned W_V     = $clog2(V_TOTAL);
   localparam int unsigned BAR_W   = H_DISP / 8;
   localparam int unsigned H_ACT   = H_SYNC + H_BP;
   localparam int unsigned V_ACT   = V_SYNC + V_BP;

   localparam logic [W_H-1:0] H_LAST_C   = W_H'(H_TOTAL - 1);
   localparam logic [W_H-1:0] H_SYNC_C   = W_H'(H_SYNC);
   localparam logic [W_H-1:0] H_ACT_S_C  = W_H'(H_ACT);
   localparam logic [W_H-1:0] H_ACT_E_C  = W_H'(H_ACT + H_DISP - 1);
   localparam logic [W_H-1:0] BAR_LAST_C = W_H'(BAR_W - 1);
   localparam logic [W_V-1:0] V_LAST_C   = W_V'(V_TOTAL - 1);
   localparam logic [W_V-1:0] V_SYNC_C   = W_V'(V_SYNC);
   localparam logic [W_V-1:0] V_ACT_S_C  = W_V'(V_ACT);
   localparam logic [W_V-1:0] V_ACT_E_C  = W_V'(V_ACT + V_DISP - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   logic [1:0]     r_state;
   logic [W_H-1:0] r_h_cnt;
   logic [W_V-1:0] r_v_cnt;
   logic [1:0]     r_mode;
   logic [15:0]    r_solid;
   logic [W_H-1:0] r_bar_px;
   logic [2:0]     r_bar_idx;
   logic           r_vs, r_hs, r_de, r_busy;
   logic [15:0]    r_data;
   logic [15:0]    r_frame_cnt;

   logic [1:0]     w_state_nxt;
   logic [W_H-1:0] w_h_nxt, w_bar_px_nxt;
   logic [W_V-1:0] w_v_nxt;
   logic [1:0]     w_mode_nxt;
   logic [15:0]    w_solid_nxt;
   logic [2:0]     w_bar_idx_nxt;
   logic           w_vs_nxt, w_hs_nxt, w_de_nxt, w_busy_nxt;
   logic [15:0]    w_data_nxt, w_fc_nxt;
   logic           w_adv;

   // Region decode straight from the counters
   logic        w_h_last, w_v_last, w_frame_end;
   logic        w_hs, w_vs, w_h_act, w_v_act, w_de;
   logic [15:0] w_x, w_y, w_xp, w_pix;
   logic [2:0]  w_pre_idx;
   logic [W_H-1:0] w_pre_px;
   logic        w_unused;

   assign w_h_last    = (r_h_cnt == H_LAST_C);
   assign w_v_last    = (r_v_cnt == V_LAST_C);
   assign w_frame_end = w_h_last && w_v_last;
   assign w_hs        = (r_h_cnt < H_SYNC_C);
   assign w_vs        = (r_v_cnt < V_SYNC_C);
   assign w_h_act     = (r_h_cnt >= H_ACT_S_C) && (r_h_cnt <= H_ACT_E_C);
   assign w_v_act     = (r_v_cnt >= V_ACT_S_C) && (r_v_cnt <= V_ACT_E_C);
   assign w_de        = w_h_act && w_v_act;
   assign w_x         = 16'(r_h_cnt) - 16'(H_ACT);
   assign w_y         = 16'(r_v_cnt) - 16'(V_ACT);

`ifdef VI_PATTERN_GEN_SCROLL_EN
   localparam logic [15:0] H_DISP_C = 16'(H_DISP);
   localparam logic [15:0] BAR_W_C  = 16'(BAR_W);
   logic [15:0] w_off, w_x_sum;
   assign w_off     = 16'(r_frame_cnt[7:0]) % H_DISP_C;
   assign w_x_sum   = w_x + w_off;
   assign w_xp      = (w_x_sum >= H_DISP_C) ? (w_x_sum - H_DISP_C) : w_x_sum;
   assign w_pre_idx = 3'(w_off / BAR_W_C);
   assign w_pre_px  = W_H'(w_off % BAR_W_C);
`else
   assign w_xp      = w_x;
   assign w_pre_idx = 3'd0;
   assign w_pre_px  = '0;
`endif

   assign w_unused = ^{w_xp, w_y};

   // Pattern colour for the current counter position
   always_comb begin
      w_pix = 16'h0000;
      case (r_mode)
         2'b00: w_pix = r_solid;
         2'b01: begin
            case (r_bar_idx)
               3'd0:    w_pix = 16'hFFFF;
               3'd1:    w_pix = 16'hFFE0;
               3'd2:    w_pix = 16'h07FF;
               3'd3:    w_pix = 16'h07E0;
               3'd4:    w_pix = 16'hF81F;
               3'd5:    w_pix = 16'hF800;
               3'd6:    w_pix = 16'h001F;
               default: w_pix = 16'h0000;
            endcase
         end
         2'b10:   w_pix = {w_xp[7:3], w_xp[7:2], w_xp[7:3]};
         default: w_pix = (w_xp[CHECK_LOG2] ^ w_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
      endcase
   end

   // Next-state, counter and output computation
   always_comb begin
      w_state_nxt   = r_state;
      w_h_nxt       = r_h_cnt;
      w_v_nxt       = r_v_cnt;
      w_mode_nxt    = r_mode;
      w_solid_nxt   = r_solid;
      w_bar_px_nxt  = r_bar_px;
      w_bar_idx_nxt = r_bar_idx;
      w_fc_nxt      = r_frame_cnt;
      w_vs_nxt      = 1'b0;
      w_hs_nxt      = 1'b0;
      w_de_nxt      = 1'b0;
      w_data_nxt    = 16'h0000;
      w_adv         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_h_nxt       = '0;
            w_v_nxt       = '0;
            w_bar_px_nxt  = w_pre_px;
            w_bar_idx_nxt = w_pre_idx;
            if (en) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_adv = 1'b1;
            if (r_h_cnt == '0 && r_v_cnt == '0) begin
               w_mode_nxt  = mode;
               w_solid_nxt = solid_color;
            end
            if (!en) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            w_adv = 1'b1;
            if (en)               w_state_nxt = S_RUN;
            else if (w_frame_end) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_adv) begin
         w_vs_nxt   = w_vs;
         w_hs_nxt   = w_hs;
         w_de_nxt   = w_de;
         w_data_nxt = w_de ? w_pix : 16'h0000;
         w_h_nxt    = w_h_last ? '0 : r_h_cnt + W_H'(1);
         if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v_cnt + W_V'(1);
         if (w_frame_end) w_fc_nxt = r_frame_cnt + 16'd1;
         // Bar sub-counter tracks x of the current h_cnt; reloaded at each line wrap
         if (w_h_last) begin
            w_bar_px_nxt  = w_pre_px;
            w_bar_idx_nxt = w_pre_idx;
         end else if (w_h_act) begin
            if (r_bar_px == BAR_LAST_C) begin
               w_bar_px_nxt  = '0;
               w_bar_idx_nxt = r_bar_idx + 3'd1;
            end else begin
               w_bar_px_nxt  = r_bar_px + W_H'(1);
            end
         end
      end

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_mode      <= 2'b00;
         r_solid     <= 16'h0000;
         r_bar_px    <= '0;
         r_bar_idx   <= 3'd0;
         r_vs        <= 1'b0;
         r_hs        <= 1'b0;
         r_de        <= 1'b0;
         r_data      <= 16'h0000;
         r_frame_cnt <= 16'h0000;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_h_cnt     <= w_h_nxt;
         r_v_cnt     <= w_v_nxt;
         r_mode      <= w_mode_nxt;
         r_solid     <= w_solid_nxt;
         r_bar_px    <= w_bar_px_nxt;
         r_bar_idx   <= w_bar_idx_nxt;
         r_vs        <= w_vs_nxt;
         r_hs        <= w_hs_nxt;
         r_de        <= w_de_nxt;
         r_data      <= w_data_nxt;
         r_frame_cnt <= w_fc_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign vo_vs     = r_vs;
   assign vo_hs     = r_hs;
   assign vo_de     = r_de;
   assign vo_data   = r_data;
   assign frame_cnt = r_frame_cnt;
   assign busy      = r_busy;

endmodule

// File: doc/vi_pattern_gen.md
Name: vi_pattern_gen

Overview:
Video source that generates the `vi_vs` / `vi_de` / `vi_data` (RGB565) stream consumed by the video-processing input.
- Produces complete frame timing: sync, back porch, active and front porch, horizontal and vertical.
- Fills the active region with selectable test patterns.
- Sits in front of the VP chain as a camera/DVP substitute for bring-up and regression.
- Single clock domain; the pixel clock is `clk`.

Parameters:
- H_DISP, 1280, active pixels per line (must be divisible by 8)
- H_FP, 110, horizontal front porch in clocks
- H_SYNC, 40, hsync width in clocks
- H_BP, 220, horizontal back porch in clocks
- V_DISP, 720, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BP, 20, vertical back porch in lines
- CHECK_LOG2, 5, log2 of checkerboard square size in pixels

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- mode  in  2  00 solid, 01 colour bars, 10 grey ramp, 11 checkerboard
- solid_color  in  16  RGB565 value for mode 00
- vo_vs  out  1  vertical sync, active high
- vo_hs  out  1  horizontal sync, active high
- vo_de  out  1  active-video data enable
- vo_data  out  16  RGB565 pixel {R[4:0], G[5:0], B[4:0]}; 0 when vo_de=0
- frame_cnt  out  16  completed-frame counter
- busy  out  1  high while in RUN or STOP_PEND

Behaviour:
- Clock/reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; `h_cnt` = `v_cnt` = 0; state IDLE; latched mode = 00.
- Timing constants: H_TOTAL = H_SYNC+H_BP+H_DISP+H_FP; V_TOTAL = V_SYNC+V_BP+V_DISP+V_FP.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on each `h_cnt` wrap, 0..V_TOTAL-1, then wraps.
- Region decode (from counters):
  - hs = (h_cnt < H_SYNC)
  - vs = (v_cnt < V_SYNC)
  - de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_DISP-1] AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_DISP-1]
  - x = h_cnt-(H_SYNC+H_BP); y = v_cnt-(V_SYNC+V_BP)
- All outputs are registered: one clock of latency from counter value to `vo_*`.
- State machine:
  - IDLE: counters held at 0, outputs 0, `busy`=0. If `en`=1, go to RUN on the next edge.
  - RUN: counters advance every clock. If `en`=0, go to STOP_PEND.
  - STOP_PEND: counters keep advancing. At the frame-end point, go to IDLE. If `en` returns to 1 first, go back to RUN with no disturbance to the frame.
  - Frame-end point: `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1.
- First frame: `en` sampled high at edge k gives state RUN after edge k. `vo_vs`=`vo_hs`=1 after edge k+1, i.e. the frame begins with the vsync line.
- Mode latching: `mode` and `solid_color` are latched when the counters are (0,0) in RUN. Changes mid-frame do not affect the current frame.
- frame_cnt: increments by 1 at every frame-end point in RUN or STOP_PEND; wraps FFFF->0000.
- Simultaneous frame-end and `en`=0 in RUN: the frame is counted, the state goes to STOP_PEND, and exactly one further full frame is emitted.
- Patterns (`vo_data` during `vo_de`):
  - 00: `solid_color`.
  - 01: 8 equal bars, each H_DISP/8 wide. Bar index comes from a sub-counter reset at line start (no divider). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 10: R = x[7:3], G = x[7:2], B = x[7:3].
  - 11: (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? FFFF : 0000.
- Reset mid-frame: on the next edge, all outputs are 0 and the state is IDLE. No partial frame completes.

Optional Feature:
- Macro: VI_PATTERN_GEN_SCROLL_EN
- Defined: x used for pattern selection becomes (x + frame_cnt[7:0]) modulo H_DISP, so patterns 01/10/11 scroll left by 1 pixel per frame. The bar sub-counter is preloaded accordingly at line start.
- Undefined: patterns are static; no adder or preload logic is generated.

Test Plan:
All scenarios use small overrides: H_DISP=16, H_FP=2, H_SYNC=2, H_BP=2, V_DISP=4, V_FP=1, V_SYNC=1, V_BP=1, CHECK_LOG2=2. This gives H_TOTAL=22, V_TOTAL=7, 154 clocks per frame.
1. Reset, `en`=1, mode=00, `solid_color`=1234 -> per frame exactly 64 `vo_de` cycles, all 1234; `vo_hs` high 2 of every 22 clocks; `vo_vs` high 22 clocks per 154; `frame_cnt`=2 after 308 clocks of RUN.
2. mode=01 -> each active line reads FFFF,FFFF,FFE0,FFE0,...,0000,0000 (2 pixels per bar); `vo_data`=0 whenever `vo_de`=0.
3. mode=11 -> line y=0 reads 0000×4, FFFF×4, 0000×4, FFFF×4; lines 0-3 are identical (y bit 2 = 0).
4. Drop `en` mid-frame -> the current frame completes; `busy` falls exactly at frame end; outputs stay 0; `frame_cnt` held.
5. Change mode 00->10 mid-frame -> the remainder of that frame is unchanged; the next frame shows ramp x=8 -> `vo_data`=0841.
6. Assert `rst` mid-active-line -> after the next edge all outputs are 0 and `busy`=0; re-enabling restarts with a vsync line and `frame_cnt` at 0.
